// File: rtl/id_ex_hazard_latch.sv
// ID/EX pipeline register with load-use hazard detection.
//
// Sits directly downstream of decode. Each rising edge it either holds
// (debug unit disabled), writes a bubble (branch flush or load-use stall),
// or captures the decoded ID instruction. A load-use stall also freezes
// PC and IF/ID for one cycle and bumps a stall counter for the debug unit.
//
// Front-end handshake: o_pc_write / o_if_id_write act as the "ready" back
// to the fetch side. When they are 0 the IF/ID instruction must be held
// and re-presented unchanged next cycle. When they are 1 the instruction
// currently on i_id_* is consumed at this edge (captured into EX, or
// squashed if i_flush is set). They are 0 whenever i_enable is 0 or a
// load-use stall is being inserted.
module id_ex_hazard_latch #(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CTRL = 12,
    parameter int NB_CNT  = 32
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_enable,
    input  logic               i_flush,
    input  logic [NB_CTRL-1:0] i_id_ctrl,
    input  logic [NB_DATA-1:0] i_id_rs_data,
    input  logic [NB_DATA-1:0] i_id_rt_data,
    input  logic [NB_DATA-1:0] i_id_imm,
    input  logic [NB_DATA-1:0] i_id_pc,
    input  logic [NB_REG-1:0]  i_id_rs,
    input  logic [NB_REG-1:0]  i_id_rt,
    input  logic [NB_REG-1:0]  i_id_rd,
    input  logic               i_id_uses_rs,
    input  logic               i_id_uses_rt,
    output logic [NB_CTRL-1:0] o_ex_ctrl,
    output logic [NB_DATA-1:0] o_ex_rs_data,
    output logic [NB_DATA-1:0] o_ex_rt_data,
    output logic [NB_DATA-1:0] o_ex_imm,
    output logic [NB_DATA-1:0] o_ex_pc,
    output logic [NB_REG-1:0]  o_ex_rs,
    output logic [NB_REG-1:0]  o_ex_rt,
    output logic [NB_REG-1:0]  o_ex_rd,
    output logic               o_ex_valid,
    output logic               o_stall,
    output logic               o_pc_write,
    output logic               o_if_id_write,
    output logic [NB_CNT-1:0]  o_stall_count
);

    // Bit positions inside the packed control word.
    localparam int CTRL_MEM_READ = 1;

    // Per-edge update action, in decreasing priority (reset handled in the
    // register block itself since it overrides everything).
    localparam logic [1:0] ACT_HOLD  = 2'd0;
    localparam logic [1:0] ACT_FLUSH = 2'd1;
    localparam logic [1:0] ACT_STALL = 2'd2;
    localparam logic [1:0] ACT_LOAD  = 2'd3;

    localparam logic [NB_CNT-1:0] CNT_ONE = {{(NB_CNT-1){1'b0}}, 1'b1};

    // EX-stage registers and their next-state values.
    logic [NB_CTRL-1:0] ctrl_q,    ctrl_d;
    logic [NB_DATA-1:0] rs_data_q, rs_data_d;
    logic [NB_DATA-1:0] rt_data_q, rt_data_d;
    logic [NB_DATA-1:0] imm_q,     imm_d;
    logic [NB_DATA-1:0] pc_q,      pc_d;
    logic [NB_REG-1:0]  rs_q,      rs_d;
    logic [NB_REG-1:0]  rt_q,      rt_d;
    logic [NB_REG-1:0]  rd_q,      rd_d;
    logic               valid_q,   valid_d;
    logic [NB_CNT-1:0]  cnt_q,     cnt_d;

    logic       ex_is_load;
    logic       rs_hit;
    logic       rt_hit;
    logic       hazard;
    logic       stall;
    logic       front_write;
    logic [1:0] action;

    // Load-use detection against the instruction currently in EX. A load
    // into $0 or a bubble in EX can never create a dependency.
    always_comb begin
        ex_is_load  = valid_q & ctrl_q[CTRL_MEM_READ] & (rt_q != '0);
        rs_hit      = i_id_uses_rs & (i_id_rs == rt_q);
        rt_hit      = i_id_uses_rt & (i_id_rt == rt_q);
        hazard      = ex_is_load & (rs_hit | rt_hit);
        // A flush discards the dependent instruction anyway, and a disabled
        // pipeline is frozen, so neither reports a stall.
        stall       = hazard & ~i_flush & i_enable;
        front_write = i_enable & ~stall;
    end

    // Select the register update action for this edge.
    always_comb begin
        action = ACT_LOAD;
        if (!i_enable) begin
            action = ACT_HOLD;
        end else if (i_flush) begin
            action = ACT_FLUSH;
        end else if (hazard) begin
            action = ACT_STALL;
        end
    end

    // Next-state values for every EX register and the stall counter.
    always_comb begin
        ctrl_d    = ctrl_q;
        rs_data_d = rs_data_q;
        rt_data_d = rt_data_q;
        imm_d     = imm_q;
        pc_d      = pc_q;
        rs_d      = rs_q;
        rt_d      = rt_q;
        rd_d      = rd_q;
        valid_d   = valid_q;
        cnt_d     = cnt_q;
        case (action)
            ACT_FLUSH, ACT_STALL: begin
                // Bubble: everything cleared so no later stage can write and
                // the bubble itself cannot look like a load next cycle.
                ctrl_d    = '0;
                rs_data_d = '0;
                rt_data_d = '0;
                imm_d     = '0;
                pc_d      = '0;
                rs_d      = '0;
                rt_d      = '0;
                rd_d      = '0;
                valid_d   = 1'b0;
                if (action == ACT_STALL) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            ACT_LOAD: begin
                ctrl_d    = i_id_ctrl;
                rs_data_d = i_id_rs_data;
                rt_data_d = i_id_rt_data;
                imm_d     = i_id_imm;
                pc_d      = i_id_pc;
                rs_d      = i_id_rs;
                rt_d      = i_id_rt;
                rd_d      = i_id_rd;
                valid_d   = 1'b1;
            end
            default: begin
                // ACT_HOLD: keep every register as it is.
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clock) begin
        if (!i_reset) begin
            ctrl_q    <= '0;
            rs_data_q <= '0;
            rt_data_q <= '0;
            imm_q     <= '0;
            pc_q      <= '0;
            rs_q      <= '0;
            rt_q      <= '0;
            rd_q      <= '0;
            valid_q   <= 1'b0;
            cnt_q     <= '0;
        end else begin
            ctrl_q    <= ctrl_d;
            rs_data_q <= rs_data_d;
            rt_data_q <= rt_data_d;
            imm_q     <= imm_d;
            pc_q      <= pc_d;
            rs_q      <= rs_d;
            rt_q      <= rt_d;
            rd_q      <= rd_d;
            valid_q   <= valid_d;
            cnt_q     <= cnt_d;
        end
    end

    assign o_ex_ctrl     = ctrl_q;
    assign o_ex_rs_data  = rs_data_q;
    assign o_ex_rt_data  = rt_data_q;
    assign o_ex_imm      = imm_q;
    assign o_ex_pc       = pc_q;
    assign o_ex_rs       = rs_q;
    assign o_ex_rt       = rt_q;
    assign o_ex_rd       = rd_q;
    assign o_ex_valid    = valid_q;
    assign o_stall       = stall;
    assign o_pc_write    = front_write;
    assign o_if_id_write = front_write;
    assign o_stall_count = cnt_q;

endmodule

// File: tb/tb_id_ex_hazard_latch.sv
// Directed bench for id_ex_hazard_latch (stall counter narrowed to 4 bits
// so the wrap is reachable quickly).
module tb_id_ex_hazard_latch;

    localparam int NB_DATA = 32;
    localparam int NB_REG  = 5;
    localparam int NB_CTRL = 12;
    localparam int NB_CNT  = 4;

    logic               i_clock;
    logic               i_reset;
    logic               i_enable;
    logic               i_flush;
    logic [NB_CTRL-1:0] i_id_ctrl;
    logic [NB_DATA-1:0] i_id_rs_data;
    logic [NB_DATA-1:0] i_id_rt_data;
    logic [NB_DATA-1:0] i_id_imm;
    logic [NB_DATA-1:0] i_id_pc;
    logic [NB_REG-1:0]  i_id_rs;
    logic [NB_REG-1:0]  i_id_rt;
    logic [NB_REG-1:0]  i_id_rd;
    logic               i_id_uses_rs;
    logic               i_id_uses_rt;
    logic [NB_CTRL-1:0] o_ex_ctrl;
    logic [NB_DATA-1:0] o_ex_rs_data;
    logic [NB_DATA-1:0] o_ex_rt_data;
    logic [NB_DATA-1:0] o_ex_imm;
    logic [NB_DATA-1:0] o_ex_pc;
    logic [NB_REG-1:0]  o_ex_rs;
    logic [NB_REG-1:0]  o_ex_rt;
    logic [NB_REG-1:0]  o_ex_rd;
    logic               o_ex_valid;
    logic               o_stall;
    logic               o_pc_write;
    logic               o_if_id_write;
    logic [NB_CNT-1:0]  o_stall_count;

    int checks = 0;
    int errors = 0;

    id_ex_hazard_latch #(
        .NB_DATA(NB_DATA),
        .NB_REG (NB_REG),
        .NB_CTRL(NB_CTRL),
        .NB_CNT (NB_CNT)
    ) dut (
        .i_clock      (i_clock),
        .i_reset      (i_reset),
        .i_enable     (i_enable),
        .i_flush      (i_flush),
        .i_id_ctrl    (i_id_ctrl),
        .i_id_rs_data (i_id_rs_data),
        .i_id_rt_data (i_id_rt_data),
        .i_id_imm     (i_id_imm),
        .i_id_pc      (i_id_pc),
        .i_id_rs      (i_id_rs),
        .i_id_rt      (i_id_rt),
        .i_id_rd      (i_id_rd),
        .i_id_uses_rs (i_id_uses_rs),
        .i_id_uses_rt (i_id_uses_rt),
        .o_ex_ctrl    (o_ex_ctrl),
        .o_ex_rs_data (o_ex_rs_data),
        .o_ex_rt_data (o_ex_rt_data),
        .o_ex_imm     (o_ex_imm),
        .o_ex_pc      (o_ex_pc),
        .o_ex_rs      (o_ex_rs),
        .o_ex_rt      (o_ex_rt),
        .o_ex_rd      (o_ex_rd),
        .o_ex_valid   (o_ex_valid),
        .o_stall      (o_stall),
        .o_pc_write   (o_pc_write),
        .o_if_id_write(o_if_id_write),
        .o_stall_count(o_stall_count)
    );

    // Clock
    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    // Advance one rising edge; registered outputs are sampled 1 ns later.
    task automatic tick();
        @(posedge i_clock);
        #1;
    endtask

    // Let combinational outputs settle after an input change.
    task automatic settle();
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_id(input logic [NB_CTRL-1:0] ctrl,
                            input logic [NB_REG-1:0] rs, input logic [NB_REG-1:0] rt,
                            input logic [NB_REG-1:0] rd,
                            input logic urs, input logic urt,
                            input logic [NB_DATA-1:0] imm, input logic [NB_DATA-1:0] pc,
                            input logic [NB_DATA-1:0] rsd, input logic [NB_DATA-1:0] rtd);
        i_id_ctrl    = ctrl;
        i_id_rs      = rs;
        i_id_rt      = rt;
        i_id_rd      = rd;
        i_id_uses_rs = urs;
        i_id_uses_rt = urt;
        i_id_imm     = imm;
        i_id_pc      = pc;
        i_id_rs_data = rsd;
        i_id_rt_data = rtd;
    endtask

    initial begin
        i_reset  = 1'b0;
        i_enable = 1'b1;
        i_flush  = 1'b0;
        drive_id('0, '0, '0, '0, 1'b0, 1'b0, '0, '0, '0, '0);

        // Reset for two cycles.
        tick();
        tick();
        check("rst_valid", 32'(o_ex_valid), 32'd0);
        check("rst_ctrl", 32'(o_ex_ctrl), 32'd0);
        check("rst_imm", o_ex_imm, 32'd0);
        check("rst_count", 32'(o_stall_count), 32'd0);
        check("rst_stall", 32'(o_stall), 32'd0);

        // Release reset and load a plain instruction.
        i_reset = 1'b1;
        drive_id(12'h001, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 32'hFFFF8000, 32'h4, 32'h11, 32'h22);
        tick();
        check("load_imm", o_ex_imm, 32'hFFFF8000);
        check("load_valid", 32'(o_ex_valid), 32'd1);
        check("load_ctrl", 32'(o_ex_ctrl), 32'h001);
        check("load_rd", 32'(o_ex_rd), 32'd3);
        check("load_pc", o_ex_pc, 32'h4);
        check("load_rt_data", o_ex_rt_data, 32'h22);
        check("load_stall", 32'(o_stall), 32'd0);
        check("load_count", 32'(o_stall_count), 32'd0);

        // Put a load (mem_read) with rt=5 into EX.
        drive_id(12'h003, 5'd1, 5'd5, 5'd0, 1'b1, 1'b0, 32'h4, 32'h8, '0, '0);
        tick();
        check("lw_ctrl", 32'(o_ex_ctrl), 32'h003);
        check("lw_rt", 32'(o_ex_rt), 32'd5);

        // Dependent instruction reading rs=5: stall this cycle.
        drive_id(12'h001, 5'd5, 5'd6, 5'd7, 1'b1, 1'b1, 32'h0, 32'hC, 32'hAA, 32'hBB);
        settle();
        check("lu_stall", 32'(o_stall), 32'd1);
        check("lu_pc_write", 32'(o_pc_write), 32'd0);
        check("lu_if_id_write", 32'(o_if_id_write), 32'd0);
        tick();
        check("bub_ctrl", 32'(o_ex_ctrl), 32'd0);
        check("bub_valid", 32'(o_ex_valid), 32'd0);
        check("bub_rs", 32'(o_ex_rs), 32'd0);
        check("bub_pc", o_ex_pc, 32'd0);
        check("bub_count", 32'(o_stall_count), 32'd1);
        check("bub_stall_clear", 32'(o_stall), 32'd0);
        check("bub_pc_write", 32'(o_pc_write), 32'd1);
        // Same IF/ID instruction re-presented: now it loads.
        tick();
        check("reload_ctrl", 32'(o_ex_ctrl), 32'h001);
        check("reload_rs", 32'(o_ex_rs), 32'd5);
        check("reload_rd", 32'(o_ex_rd), 32'd7);
        check("reload_rs_data", o_ex_rs_data, 32'hAA);
        check("reload_valid", 32'(o_ex_valid), 32'd1);
        check("reload_count", 32'(o_stall_count), 32'd1);

        // Load into $0 never stalls.
        drive_id(12'h003, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, '0, 32'h10, '0, '0);
        tick();
        drive_id(12'h001, 5'd0, 5'd4, 5'd8, 1'b1, 1'b0, '0, 32'h14, '0, '0);
        settle();
        check("r0_no_stall", 32'(o_stall), 32'd0);
        check("r0_pc_write", 32'(o_pc_write), 32'd1);

        // Now put a load with rt=7 into EX (no dependency on the $0 load).
        drive_id(12'h003, 5'd0, 5'd7, 5'd0, 1'b0, 1'b0, '0, 32'h18, '0, '0);
        tick();
        check("lw7_rt", 32'(o_ex_rt), 32'd7);
        // rs matches but is not used: no stall.
        drive_id(12'h001, 5'd7, 5'd1, 5'd2, 1'b0, 1'b1, '0, 32'h1C, '0, '0);
        settle();
        check("unused_rs_no_stall", 32'(o_stall), 32'd0);
        // rt match with uses_rt: stall.
        i_id_rt = 5'd7;
        settle();
        check("rt_match_stall", 32'(o_stall), 32'd1);

        // Flush wins over the hazard.
        drive_id(12'h001, 5'd7, 5'd1, 5'd2, 1'b1, 1'b0, '0, 32'h1C, '0, '0);
        i_flush = 1'b1;
        settle();
        check("flush_stall", 32'(o_stall), 32'd0);
        check("flush_pc_write", 32'(o_pc_write), 32'd1);
        check("flush_if_id_write", 32'(o_if_id_write), 32'd1);
        tick();
        i_flush = 1'b0;
        check("flush_valid", 32'(o_ex_valid), 32'd0);
        check("flush_ctrl", 32'(o_ex_ctrl), 32'd0);
        check("flush_count", 32'(o_stall_count), 32'd1);

        // Hold: put a load rt=3 in EX, then disable with a dependent ID.
        drive_id(12'h007, 5'd2, 5'd3, 5'd4, 1'b1, 1'b1, 32'h10, 32'h20, 32'h5, 32'h6);
        tick();
        check("pre_hold_ctrl", 32'(o_ex_ctrl), 32'h007);
        i_enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_id(12'h001, 5'd3, 5'd9, 5'd10, 1'b1, 1'b0, 32'(100 + i), 32'(32'h40 + 4 * i), 32'(i), '0);
            settle();
            check("hold_stall", 32'(o_stall), 32'd0);
            check("hold_pc_write", 32'(o_pc_write), 32'd0);
            check("hold_if_id_write", 32'(o_if_id_write), 32'd0);
            tick();
            check("hold_ctrl", 32'(o_ex_ctrl), 32'h007);
            check("hold_pc", o_ex_pc, 32'h20);
            check("hold_imm", o_ex_imm, 32'h10);
            check("hold_count", 32'(o_stall_count), 32'd1);
        end
        // Re-enable: hazard evaluation resumes.
        i_enable = 1'b1;
        settle();
        check("resume_stall", 32'(o_stall), 32'd1);
        tick();
        check("resume_valid", 32'(o_ex_valid), 32'd0);
        check("resume_count", 32'(o_stall_count), 32'd2);

        // Counter wrap: 13 more bubbles bring the count to 15, one more wraps.
        for (int i = 0; i < 14; i++) begin
            drive_id(12'h003, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, '0, 32'h80, '0, '0);
            tick();
            drive_id(12'h001, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0, '0, 32'h84, '0, '0);
            settle();
            check("wrap_stall", 32'(o_stall), 32'd1);
            tick();
            if (i == 12) begin
                check("count_f", 32'(o_stall_count), 32'hF);
            end
        end
        check("count_wrap", 32'(o_stall_count), 32'h0);

        // Reset asserted during a stall.
        drive_id(12'h003, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 32'h3, 32'h90, 32'h1, 32'h2);
        tick();
        drive_id(12'h001, 5'd9, 5'd1, 5'd2, 1'b1, 1'b0, '0, 32'h94, '0, '0);
        settle();
        check("pre_rst_stall", 32'(o_stall), 32'd1);
        i_reset = 1'b0;
        tick();
        i_reset = 1'b1;
        settle();
        check("mid_rst_stall", 32'(o_stall), 32'd0);
        check("mid_rst_valid", 32'(o_ex_valid), 32'd0);
        check("mid_rst_ctrl", 32'(o_ex_ctrl), 32'd0);
        check("mid_rst_rt", 32'(o_ex_rt), 32'd0);
        check("mid_rst_count", 32'(o_stall_count), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_hazard_latch.md
Name: id_ex_hazard_latch

Overview:
- ID/EX pipeline register placed directly downstream of the decode stage.
- Captures the decoded fields: the sign-extended immediate, register-file read data, register indices, PC and the packed control word.
- Contains load-use hazard detection against the instruction currently held in EX; on a hazard it inserts a bubble and freezes PC and IF/ID.
- Honours a branch flush and the debug-unit enable, and keeps a stall counter for the debug unit.

Parameters:
NB_DATA, 32, width of register data, immediate and PC
NB_REG, 5, register index width
NB_CTRL, 12, packed control word width; bit0 reg_write, bit1 mem_read, bit2 mem_write, remaining bits opaque
NB_CNT, 32, stall counter width

Ports:
i_clock  in  1  clock, all state updates on rising edge
i_reset  in  1  synchronous reset, active-low
i_enable  in  1  debug-unit step/run enable; 0 = whole block holds
i_flush  in  1  taken branch/jump resolved downstream; squash the ID instruction
i_id_ctrl  in  NB_CTRL  decoded control word
i_id_rs_data  in  NB_DATA  register file rs read data
i_id_rt_data  in  NB_DATA  register file rt read data
i_id_imm  in  NB_DATA  sign-extended immediate
i_id_pc  in  NB_DATA  PC+4 of the ID instruction
i_id_rs, i_id_rt, i_id_rd  in  NB_REG each  register indices
i_id_uses_rs, i_id_uses_rt  in  1 each  ID instruction actually reads rs / rt
o_ex_ctrl, o_ex_rs_data, o_ex_rt_data, o_ex_imm, o_ex_pc, o_ex_rs, o_ex_rt, o_ex_rd  out  matching widths  registered copies
o_ex_valid  out  1  EX holds a real instruction (0 = bubble)
o_stall  out  1  load-use hazard stall this cycle
o_pc_write  out  1  PC may update
o_if_id_write  out  1  IF/ID may update
o_stall_count  out  NB_CNT  cycles in which a hazard bubble was inserted

Behaviour:
- Reset (i_reset=0 at clock edge): all registered outputs go to 0, including o_ex_valid and o_stall_count. Reset overrides every other input.
- Hazard (combinational): `hazard = o_ex_valid & o_ex_ctrl[1] & (o_ex_rt != 0) & ((i_id_uses_rs & i_id_rs == o_ex_rt) | (i_id_uses_rt & i_id_rt == o_ex_rt))`.
- o_stall = hazard & ~i_flush & i_enable.
- o_pc_write = o_if_id_write = i_enable & ~o_stall.
- Register update priority at each edge: reset > hold (i_enable=0) > flush > stall > load.
  - Hold: every register keeps its value and the counter does not change.
  - Flush: bubble is written; o_stall_count is not incremented.
  - Stall: bubble is written; o_stall_count increments by 1, wrapping from all-ones to 0.
  - Load: all i_id_* values are captured and o_ex_valid is set to 1.
- Bubble: o_ex_ctrl and o_ex_valid are cleared. The data, immediate, index and PC registers also clear to 0, so EX/MEM/WB cannot write.
- Latency: one cycle from ID inputs to EX outputs.
- Stall length: one cycle per load-use. The bubble carries mem_read=0, so the hazard self-clears on the next cycle. The IF/ID instruction is held and is re-presented unchanged on the next cycle.
- Register $0 as a load destination never stalls.
- A load in EX whose o_ex_valid=0 never stalls.
- Flush and hazard in the same cycle: o_stall=0, PC/IF-ID writes stay enabled so the branch target loads, and the counter is unchanged.
- i_enable=0: o_stall=0, o_pc_write=0 and o_if_id_write=0 (the pipeline is frozen). Hazard evaluation resumes when i_enable returns to 1.
- A mid-operation reset during a stall clears the bubble state; the first cycle after reset shows o_stall=0.

Test Plan:
- Reset then load: i_reset=0 for 2 cycles, then i_reset=1 with `i_id_imm=0xFFFF8000`, ctrl=0x001 → next cycle `o_ex_imm=0xFFFF8000`, o_ex_valid=1, o_stall=0, count=0.
- Load-use on rt: EX holds ctrl=0x002 (mem_read) with rt=5; ID has rs=5, uses_rs=1 → o_stall=1 and o_pc_write=0 that cycle. Next cycle: o_ex_ctrl=0, o_ex_valid=0, o_stall_count=1. The cycle after: the ID instruction loads and o_stall=0.
- No-stall cases:
  - EX load with rt=0 and ID rs=0 → o_stall=0.
  - EX load rt=7, ID rs=7 but uses_rs=0 → o_stall=0.
- Flush vs hazard: hazard conditions true with i_flush=1 → o_stall=0, o_pc_write=1, next o_ex_valid=0, count unchanged.
- Hold: i_enable=0 for 3 cycles with changing ID inputs → EX outputs and count are unchanged, and o_pc_write=0, o_if_id_write=0, o_stall=0.
- Counter wrap with NB_CNT=4: 16 hazard bubbles → o_stall_count reads 0xF after 15 bubbles and wraps to 0x0 after the 16th. A reset asserted during a stall → all outputs 0 on the next cycle.
